ms_rr_arbiter: RTL and testbench

Round-robin scheduler that merges three slave-side input channels (data plus one-cycle `sync` strobe, the same port style as the TestMasterSlave blocks) onto a single master-side output channel. It sits in front of a shared consumer that accepts at most one word per cycle. Each channel has a one-entry holding register, so a word arriving while its channel is still waiting is not lost silently. The block grants fairly among pending channels and reports drops through sticky overflow flags.

---
 rtl/ms_rr_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ms_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ms_rr_arbiter.sv
// ms_rr_arbiter: three-channel round-robin merge onto one strobed output.
// Each channel owns a one-entry holding register. Drops are reported
// through sticky overflow flags. Grants are registered, one word per cycle.

// Per-channel holding slot: capture, release on grant, overflow detection.
module ms_rr_chan #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_i,
  input  logic              en_i,
  input  logic              grant_i,
  input  logic              clr_ovf_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] hold_o,
  output logic              pend_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              ovf_q,  ovf_d;
  logic              cap, drop;

  // A granted slot is free again this edge, so a same-cycle sync reloads it.
  always_comb begin
    cap    = sync_i & en_i;
    drop   = cap & pend_q & ~grant_i;
    hold_d = hold_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (grant_i) pend_d = 1'b0;
    if (cap && !drop) begin
      hold_d = data_i;
      pend_d = 1'b1;
    end
    // Clear first so a coincident overflow leaves the flag set.
    if (clr_ovf_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  // Slot state register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign hold_o = hold_q;
  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

module ms_rr_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_in_1,
  input  logic [DATA_W-1:0] s_in_2,
  input  logic [DATA_W-1:0] s_in_3,
  input  logic              s_in_1_sync,
  input  logic              s_in_2_sync,
  input  logic              s_in_3_sync,
  input  logic [2:0]        en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] s_out,
  output logic              s_out_notify,
  output logic [1:0]        s_out_src,
  output logic [2:0]        ovf,
  output logic              busy
);

  localparam int NUM_CH = 3;

  logic [NUM_CH-1:0]             sync_v;
  logic [NUM_CH-1:0][DATA_W-1:0] din_v;
  logic [NUM_CH-1:0][DATA_W-1:0] hold_v;
  logic [NUM_CH-1:0]             pend_v;
  logic [NUM_CH-1:0]             ovf_v;
  logic [NUM_CH-1:0]             elig;
  logic [NUM_CH-1:0]             gnt_oh;
  logic [1:0]                    gnt_idx;
  logic                          gnt_any;
  logic [1:0]                    start_idx;

  logic [DATA_W-1:0] s_out_q, s_out_d;
  logic              notify_q, notify_d;
  logic [1:0]        src_q, src_d;
  logic [1:0]        last_q, last_d;

  assign sync_v = {s_in_3_sync, s_in_2_sync, s_in_1_sync};
  assign din_v  = {s_in_3, s_in_2, s_in_1};
  assign elig   = pend_v & en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ms_rr_chan #(.DATA_W(DATA_W)) u_chan (
        .clk       (clk),
        .rst       (rst),
        .sync_i    (sync_v[gi]),
        .en_i      (en[gi]),
        .grant_i   (gnt_oh[gi]),
        .clr_ovf_i (clr_ovf),
        .data_i    (din_v[gi]),
        .hold_o    (hold_v[gi]),
        .pend_o    (pend_v[gi]),
        .ovf_o     (ovf_v[gi])
      );
    end
  endgenerate

  // Search begins at the channel after the last grant (last is 1-based, 3 wraps to 1).
  always_comb begin
    case (last_q)
      2'd1:    start_idx = 2'd1;
      2'd2:    start_idx = 2'd2;
      default: start_idx = 2'd0;
    endcase
  end

  // Rotating priority pick among eligible channels.
  always_comb begin
    logic [2:0] idx;
    gnt_oh  = '0;
    gnt_idx = 2'd0;
    gnt_any = 1'b0;
    idx     = 3'd0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = {1'b0, start_idx} + 3'(off);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!gnt_any && elig[idx[1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[1:0];
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  // Output stage next state: present the granted word, hold data when idle.
  always_comb begin
    s_out_d  = s_out_q;
    notify_d = 1'b0;
    src_d    = 2'd0;
    last_d   = last_q;
    if (gnt_any) begin
      s_out_d  = hold_v[gnt_idx];
      notify_d = 1'b1;
      src_d    = gnt_idx + 2'd1;
      last_d   = gnt_idx + 2'd1;
    end
  end

  // Output and round-robin pointer registers; last resets to 3 so channel 1 leads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_out_q  <= '0;
      notify_q <= 1'b0;
      src_q    <= 2'd0;
      last_q   <= 2'd3;
    end else begin
      s_out_q  <= s_out_d;
      notify_q <= notify_d;
      src_q    <= src_d;
      last_q   <= last_d;
    end
  end

  assign s_out        = s_out_q;
  assign s_out_notify = notify_q;
  assign s_out_src    = src_q;
  assign ovf          = ovf_v;
  assign busy         = |pend_v;

endmodule

// File: tb/tb_ms_rr_arbiter.sv
// Bench for ms_rr_arbiter: directed scenarios with literal expectations plus
// a per-cycle comparison against a channel-level behavioural model.
module tb_ms_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_in_1, s_in_2, s_in_3;
  logic        s_in_1_sync, s_in_2_sync, s_in_3_sync;
  logic [2:0]  en;
  logic        clr_ovf;
  logic [31:0] s_out;
  logic        s_out_notify;
  logic [1:0]  s_out_src;
  logic [2:0]  ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state: what each channel holds and what the output shows
  logic [31:0] m_hold [1:3];
  logic [3:1]  m_pend;
  int          m_last;
  logic [31:0] m_out;
  logic        m_note;
  int          m_src;
  logic [2:0]  m_ovf;

  always #5 clk = ~clk;

  ms_rr_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_in_1(s_in_1), .s_in_2(s_in_2), .s_in_3(s_in_3),
    .s_in_1_sync(s_in_1_sync), .s_in_2_sync(s_in_2_sync), .s_in_3_sync(s_in_3_sync),
    .en(en), .clr_ovf(clr_ovf),
    .s_out(s_out), .s_out_notify(s_out_notify), .s_out_src(s_out_src),
    .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model, applied from the rules directly.
  task automatic model_edge();
    logic        sy [1:3];
    logic [31:0] dv [1:3];
    int          g;
    sy[1] = s_in_1_sync; sy[2] = s_in_2_sync; sy[3] = s_in_3_sync;
    dv[1] = s_in_1;      dv[2] = s_in_2;      dv[3] = s_in_3;
    if (!rst) begin
      for (int k = 1; k <= 3; k++) m_hold[k] = 32'd0;
      m_pend = '0; m_last = 3; m_out = 32'd0; m_note = 1'b0; m_src = 0; m_ovf = 3'b000;
    end else begin
      g = 0;
      for (int off = 1; off <= 3; off++) begin
        int c;
        c = (m_last + off - 1) % 3 + 1;
        if (g == 0 && m_pend[c] && en[c-1]) g = c;
      end
      if (clr_ovf) m_ovf = 3'b000;
      if (g != 0) begin
        m_out = m_hold[g]; m_src = g; m_note = 1'b1; m_last = g; m_pend[g] = 1'b0;
      end else begin
        m_note = 1'b0; m_src = 0;
      end
      for (int k = 1; k <= 3; k++) begin
        if (sy[k] && en[k-1]) begin
          if (m_pend[k]) m_ovf[k-1] = 1'b1;
          else begin m_hold[k] = dv[k]; m_pend[k] = 1'b1; end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    s_in_1_sync = 1'b0; s_in_2_sync = 1'b0; s_in_3_sync = 1'b0;
  endtask

  task automatic drv(input int ch, input logic [31:0] v);
    case (ch)
      1: begin s_in_1 = v; s_in_1_sync = 1'b1; end
      2: begin s_in_2 = v; s_in_2_sync = 1'b1; end
      default: begin s_in_3 = v; s_in_3_sync = 1'b1; end
    endcase
  endtask

  initial begin
    rst = 1'b0; en = 3'b111; clr_ovf = 1'b0;
    s_in_1 = '0; s_in_2 = '0; s_in_3 = '0;
    idle();

    fork
      forever begin @(posedge clk); model_edge(); end
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          chk("cyc_s_out",  s_out, m_out);
          chk("cyc_notify", 32'(s_out_notify), 32'(m_note));
          chk("cyc_src",    32'(s_out_src), 32'(m_src));
          chk("cyc_ovf",    32'(ovf), 32'(m_ovf));
          chk("cyc_busy",   32'(busy), 32'(|m_pend));
        end
      end
    join_none

    // reset state
    step(); step();
    chk("rst_s_out", s_out, 32'h0);
    chk("rst_notify", 32'(s_out_notify), 32'd0);
    chk("rst_src", 32'(s_out_src), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cmp_en = 1'b1;
    rst = 1'b1;

    // single word on channel 2: busy one cycle, notify two cycles after sync
    drv(2, 32'h55); step(); idle();
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_early", 32'(s_out_notify), 32'd0);
    step();
    chk("single_notify", 32'(s_out_notify), 32'd1);
    chk("single_data", s_out, 32'h55);
    chk("single_src", 32'(s_out_src), 32'd2);
    chk("single_busy_lo", 32'(busy), 32'd0);
    step();
    chk("single_once", 32'(s_out_notify), 32'd0);
    chk("single_hold", s_out, 32'h55);

    // fairness: reset so last=3, burst on all channels twice -> 1,2,3 both times
    rst = 1'b0; step(); rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      drv(1, 32'd10 + 32'(r)); drv(2, 32'd20 + 32'(r)); drv(3, 32'd30 + 32'(r));
      step(); idle();
      chk("fair_wait", 32'(s_out_notify), 32'd0);
      for (int i = 1; i <= 3; i++) begin
        step();
        chk("fair_src", 32'(s_out_src), 32'(i));
        chk("fair_data", s_out, 32'(10 * i + r));
      end
      step();
      chk("fair_done", 32'(s_out_notify), 32'd0);
      chk("fair_idle", 32'(busy), 32'd0);
    end

    // grant plus reload on channel 1: one word out every cycle, no overflow
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drv(1, 32'(i + 1)); else idle();
      step();
      if (i >= 1 && i <= 4) begin
        chk("reload_notify", 32'(s_out_notify), 32'd1);
        chk("reload_data", s_out, 32'(i));
        chk("reload_ovf", 32'(ovf), 32'd0);
      end
    end
    chk("reload_end", 32'(s_out_notify), 32'd0);

    // overflow on channel 3 while channel 1 wins
    en = 3'b011;
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h100 + 32'(i)); drv(3, 32'hDEAD); step();
    end
    en = 3'b111;
    drv(1, 32'h110); drv(3, 32'h300); step();
    idle(); drv(3, 32'h301); step();
    chk("ovf_first3", s_out, 32'h300);
    chk("ovf_first3_src", 32'(s_out_src), 32'd3);
    chk("ovf_none_yet", 32'(ovf), 32'd0);
    idle(); drv(3, 32'h302); clr_ovf = 1'b1; step();
    idle(); clr_ovf = 1'b0;
    chk("ovf_flag", 32'(ovf), 32'b100);
    chk("ovf_ch1_src", 32'(s_out_src), 32'd1);
    chk("ovf_ch1_data", s_out, 32'h110);
    step();
    chk("ovf_keep_old", s_out, 32'h301);
    chk("ovf_keep_src", 32'(s_out_src), 32'd3);
    step();
    chk("ovf_sticky", 32'(ovf), 32'b100);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // enable gating: ch2 ignored, ch1 parked while disabled
    en = 3'b101;
    drv(1, 32'h51); drv(2, 32'h52); drv(3, 32'h53); step();
    idle(); en = 3'b100; step();
    chk("gate_ch3", s_out, 32'h53);
    chk("gate_ch3_src", 32'(s_out_src), 32'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("gate_parked", 32'(s_out_notify), 32'd0);
      chk("gate_busy", 32'(busy), 32'd1);
      chk("gate_ovf", 32'(ovf), 32'd0);
    end
    en = 3'b111; step();
    chk("gate_release", s_out, 32'h51);
    chk("gate_release_src", 32'(s_out_src), 32'd1);
    step();
    chk("gate_empty", 32'(busy), 32'd0);

    // reset mid-flight discards pending words; priority restarts at ch1
    drv(1, 32'h61); drv(2, 32'h62); drv(3, 32'h63); step();
    idle(); rst = 1'b0; step(); rst = 1'b1;
    chk("mid_notify", 32'(s_out_notify), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_s_out", s_out, 32'h0);
    step();
    chk("mid_quiet", 32'(s_out_notify), 32'd0);
    drv(3, 32'h73); drv(1, 32'h71); step(); idle(); step();
    chk("mid_first", 32'(s_out_src), 32'd1);
    chk("mid_first_data", s_out, 32'h71);
    step();
    chk("mid_second", 32'(s_out_src), 32'd3);
    chk("mid_second_data", s_out, 32'h73);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
